// File: rtl/vertical_node_column.sv
// Column of NUM_NODES cascaded add/bypass reduction nodes with a shift-loaded
// per-node config chain, optional saturation, sticky per-node overflow flags
// and a valid pipeline whose latency follows the bypass configuration.
module vertical_node_column #(
    parameter int F_WIDTH   = 8,
    parameter int I_WIDTH   = 8,
    parameter int NUM_NODES = 4,
    parameter int SATURATE  = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [I_WIDTH+F_WIDTH-1:0]             top_data_i,
    input  logic [NUM_NODES*(I_WIDTH+F_WIDTH)-1:0] mux_data_i,
    input  logic                                   data_vld_i,
    input  logic                                   data_ld_i,
    input  logic                                   cfg_ld_i,
    input  logic                                   cfg_en_i,
    input  logic                                   cfg_sel_i,
    input  logic                                   clr_ovf_i,
    output logic                                   cfg_en_o,
    output logic                                   cfg_sel_o,
    output logic [I_WIDTH+F_WIDTH-1:0]             out_data_o,
    output logic                                   out_vld_o,
    output logic [NUM_NODES-1:0]                   ovf_o
);

    localparam int W = I_WIDTH + F_WIDTH;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [NUM_NODES-1:0] en_q;
    logic [NUM_NODES-1:0] sel_q;
    logic [NUM_NODES-1:0] vreg_q;
    logic [NUM_NODES-1:0] ovf_q;
    logic [W-1:0]         reg_q [NUM_NODES];

    logic [NUM_NODES-1:0] vin_w;
    logic [NUM_NODES-1:0] ovf_set_w;
    logic [W-1:0]         sum_w [NUM_NODES];
    logic [W-1:0]         cur_data_w;
    logic                 cur_vld_w;
    logic [W:0]           wide_w;
    logic                 node_ovf_w;

    // Walk the column top to bottom: each node sees the previous node's output,
    // which is either its register (sel=0) or its own input passed straight through (sel=1).
    always_comb begin
        vin_w      = '0;
        ovf_set_w  = '0;
        sum_w      = '{default: '0};
        wide_w     = '0;
        node_ovf_w = 1'b0;
        cur_data_w = top_data_i;
        cur_vld_w  = data_vld_i;
        for (int unsigned k = 0; k < NUM_NODES; k++) begin
            vin_w[k]     = cur_vld_w;
            wide_w       = {cur_data_w[W-1], cur_data_w}
                         + {mux_data_i[k*W+W-1], mux_data_i[k*W +: W]};
            node_ovf_w   = wide_w[W] ^ wide_w[W-1];
            ovf_set_w[k] = en_q[k] & node_ovf_w;
            if (!en_q[k]) begin
                sum_w[k] = cur_data_w;
            end else if (node_ovf_w && (SATURATE != 0)) begin
                sum_w[k] = wide_w[W] ? SAT_MIN : SAT_MAX;
            end else begin
                sum_w[k] = wide_w[W-1:0];
            end
            if (!sel_q[k]) begin
                cur_data_w = reg_q[k];
                cur_vld_w  = vreg_q[k];
            end
        end
    end

    // Config shift chain, node data/valid registers and sticky overflow flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q   <= '0;
            sel_q  <= '0;
            vreg_q <= '0;
            ovf_q  <= '0;
            reg_q  <= '{default: '0};
        end else begin
            if (cfg_ld_i) begin
                en_q  <= (en_q << 1)  | NUM_NODES'(cfg_en_i);
                sel_q <= (sel_q << 1) | NUM_NODES'(cfg_sel_i);
            end
            if (data_ld_i) begin
                reg_q  <= sum_w;
                vreg_q <= vin_w;
            end
            // A new overflow in the same cycle as a clear keeps the flag set.
            ovf_q <= (clr_ovf_i ? '0 : ovf_q) | (data_ld_i ? ovf_set_w : '0);
        end
    end

    assign cfg_en_o   = en_q[NUM_NODES-1];
    assign cfg_sel_o  = sel_q[NUM_NODES-1];
    assign out_data_o = cur_data_w;
    assign out_vld_o  = cur_vld_w;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_vertical_node_column.sv
// Testbench for vertical_node_column: directed scenarios plus a randomized phase,
// all checked against an integer-arithmetic reference model of the column.
module tb_vertical_node_column;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int S_MAX = 32767;
    localparam int S_MIN = -32768;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [W-1:0]   top_data_i;
    logic [N*W-1:0] mux_data_i;
    logic           data_vld_i, data_ld_i, cfg_ld_i, cfg_en_i, cfg_sel_i, clr_ovf_i;
    logic           cfg_en_o, cfg_sel_o, out_vld_o;
    logic [W-1:0]   out_data_o;
    logic [N-1:0]   ovf_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: integer-valued node registers and per-node config.
    int m_reg [N];
    bit m_vreg[N];
    bit m_en  [N];
    bit m_sel [N];
    bit m_ovf [N];
    // Model combinational results for the current inputs.
    int m_sum [N];
    bit m_vin [N];
    bit m_ovs [N];
    int m_out;
    bit m_vout;

    always #5 clk = ~clk;

    vertical_node_column #(
        .F_WIDTH  (8),
        .I_WIDTH  (8),
        .NUM_NODES(N),
        .SATURATE (1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .top_data_i(top_data_i),
        .mux_data_i(mux_data_i),
        .data_vld_i(data_vld_i),
        .data_ld_i (data_ld_i),
        .cfg_ld_i  (cfg_ld_i),
        .cfg_en_i  (cfg_en_i),
        .cfg_sel_i (cfg_sel_i),
        .clr_ovf_i (clr_ovf_i),
        .cfg_en_o  (cfg_en_o),
        .cfg_sel_o (cfg_sel_o),
        .out_data_o(out_data_o),
        .out_vld_o (out_vld_o),
        .ovf_o     (ovf_o)
    );

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int mux_val(input int k);
        logic [W-1:0] v;
        v = mux_data_i[k*W +: W];
        return sx(v);
    endfunction

    // Evaluate the column for the present inputs and model state.
    function automatic void model_eval();
        int cur;
        int raw;
        bit cur_v;
        cur   = sx(top_data_i);
        cur_v = data_vld_i;
        for (int k = 0; k < N; k++) begin
            m_vin[k] = cur_v;
            if (m_en[k]) begin
                raw      = cur + mux_val(k);
                m_ovs[k] = (raw > S_MAX) || (raw < S_MIN);
                m_sum[k] = (raw > S_MAX) ? S_MAX : ((raw < S_MIN) ? S_MIN : raw);
            end else begin
                m_ovs[k] = 1'b0;
                m_sum[k] = cur;
            end
            if (!m_sel[k]) begin
                cur   = m_reg[k];
                cur_v = m_vreg[k];
            end
        end
        m_out  = cur;
        m_vout = cur_v;
    endfunction

    // Advance the model by one clock edge using the pre-edge evaluation.
    function automatic void model_update();
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                m_reg[k] = 0; m_vreg[k] = 0; m_en[k] = 0; m_sel[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (clr_ovf_i) m_ovf[k] = 1'b0;
                if (data_ld_i && m_ovs[k]) m_ovf[k] = 1'b1;
                if (data_ld_i) begin
                    m_reg[k]  = m_sum[k];
                    m_vreg[k] = m_vin[k];
                end
            end
            if (cfg_ld_i) begin
                for (int k = N - 1; k > 0; k--) begin
                    m_en[k]  = m_en[k-1];
                    m_sel[k] = m_sel[k-1];
                end
                m_en[0]  = cfg_en_i;
                m_sel[0] = cfg_sel_i;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [W-1:0] e_data;
        logic [N-1:0] e_ovf;
        e_data = W'(m_out);
        for (int k = 0; k < N; k++) e_ovf[k] = m_ovf[k];
        chk("model_data", 32'(out_data_o), 32'(e_data));
        chk("model_vld",  32'(out_vld_o),  32'(m_vout));
        chk("model_ovf",  32'(ovf_o),      32'(e_ovf));
        chk("model_en",   32'(cfg_en_o),   32'(m_en[N-1]));
        chk("model_sel",  32'(cfg_sel_o),  32'(m_sel[N-1]));
    endtask

    // One clock: inputs already driven; update model at the edge, check 1 ns later.
    task automatic cyc();
        model_eval();
        @(posedge clk);
        model_update();
        #1;
        model_eval();
        check_model();
    endtask

    task automatic idle();
        rst_i = 0; cfg_ld_i = 0; data_ld_i = 0; clr_ovf_i = 0; data_vld_i = 0;
        cfg_en_i = 0; cfg_sel_i = 0;
    endtask

    task automatic set_mux_all(input logic [W-1:0] v);
        for (int k = 0; k < N; k++) mux_data_i[k*W +: W] = v;
    endtask

    task automatic rand_data();
        top_data_i = W'($urandom);
        for (int k = 0; k < N; k++) mux_data_i[k*W +: W] = W'($urandom);
    endtask

    task automatic shift_cfg(input bit en, input bit sel);
        cfg_ld_i = 1; cfg_en_i = en; cfg_sel_i = sel;
        cyc();
        cfg_ld_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1;
        cyc();
        rst_i = 0;
    endtask

    initial begin
        idle();
        top_data_i = '0;
        mux_data_i = '0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 2; i++) begin
            rand_data();
            rst_i = 1; cfg_ld_i = 1; data_ld_i = 1; data_vld_i = 1;
            cfg_en_i = 1; cfg_sel_i = 1; clr_ovf_i = 0;
            cyc();
        end
        idle();
        chk("rst_data", 32'(out_data_o), 32'h0);
        chk("rst_vld",  32'(out_vld_o),  32'h0);
        chk("rst_ovf",  32'(ovf_o),      32'h0);
        chk("rst_en",   32'(cfg_en_o),   32'h0);
        chk("rst_sel",  32'(cfg_sel_o),  32'h0);

        // Full add through all four nodes.
        for (int i = 0; i < N; i++) shift_cfg(1, 0);
        chk("cfg_en_out", 32'(cfg_en_o), 32'h1);
        top_data_i = 16'h0100; set_mux_all(16'h0080);
        data_vld_i = 1; data_ld_i = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("add_vld_early", 32'(out_vld_o), 32'h0);
        end
        cyc();
        chk("add_vld",  32'(out_vld_o),  32'h1);
        chk("add_data", 32'(out_data_o), 32'h0300);

        // Bypass nodes 1 and 2: two-load latency, their operands ignored.
        do_reset();
        shift_cfg(1, 0); shift_cfg(1, 1); shift_cfg(1, 1); shift_cfg(1, 0);
        rand_data();
        top_data_i = 16'h0100;
        mux_data_i[0*W +: W] = 16'h0040;
        mux_data_i[3*W +: W] = 16'h0020;
        data_vld_i = 1; data_ld_i = 1;
        cyc();
        chk("byp_vld_early", 32'(out_vld_o), 32'h0);
        cyc();
        chk("byp_vld",  32'(out_vld_o),  32'h1);
        chk("byp_data", 32'(out_data_o), 32'h0160);

        // Positive saturation and sticky overflow.
        do_reset();
        for (int i = 0; i < N; i++) shift_cfg(1, 0);
        set_mux_all('0);
        top_data_i = 16'h7F00; mux_data_i[0*W +: W] = 16'h0200;
        data_vld_i = 1; data_ld_i = 1;
        cyc();
        chk("ovf_set", 32'(ovf_o), 32'h1);
        top_data_i = '0; mux_data_i[0*W +: W] = '0; data_vld_i = 0;
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_pos_data", 32'(out_data_o), 32'h7FFF);
        chk("sat_pos_vld",  32'(out_vld_o),  32'h1);
        data_ld_i = 0;
        cyc(); cyc();
        chk("ovf_sticky", 32'(ovf_o), 32'h1);
        top_data_i = 16'h7F00; mux_data_i[0*W +: W] = 16'h0200;
        data_ld_i = 1; clr_ovf_i = 1;
        cyc();
        chk("ovf_set_wins", 32'(ovf_o), 32'h1);
        data_ld_i = 0;
        cyc();
        chk("ovf_cleared", 32'(ovf_o), 32'h0);
        clr_ovf_i = 0;

        // Negative saturation.
        top_data_i = 16'h8100; mux_data_i[0*W +: W] = 16'hFE00;
        data_vld_i = 1; data_ld_i = 1;
        cyc();
        top_data_i = '0; mux_data_i[0*W +: W] = '0; data_vld_i = 0;
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_neg_data", 32'(out_data_o), 32'h8000);
        chk("sat_neg_ovf",  32'(ovf_o),      32'h1);

        // en=0 pass-through with one register (node 0), then a 3-cycle stall.
        do_reset();
        shift_cfg(0, 1); shift_cfg(0, 1); shift_cfg(0, 1); shift_cfg(0, 0);
        rand_data();
        top_data_i = 16'h1234; data_vld_i = 1; data_ld_i = 1;
        cyc();
        chk("pass_data", 32'(out_data_o), 32'h1234);
        chk("pass_vld",  32'(out_vld_o),  32'h1);
        data_ld_i = 0;
        for (int i = 0; i < 3; i++) begin
            rand_data(); data_vld_i = 0;
            cyc();
            chk("stall_data", 32'(out_data_o), 32'h1234);
            chk("stall_vld",  32'(out_vld_o),  32'h1);
        end
        top_data_i = 16'h0042; data_vld_i = 1; data_ld_i = 1;
        cyc();
        chk("resume_data", 32'(out_data_o), 32'h0042);

        // Reset mid-stream, then a clean value through the default (en=0) column.
        do_reset();
        for (int i = 0; i < N; i++) shift_cfg(1, 0);
        data_ld_i = 1;
        for (int i = 0; i < 2; i++) begin
            rand_data(); data_vld_i = 1;
            cyc();
        end
        rst_i = 1;
        cyc();
        rst_i = 0;
        chk("mid_rst_data", 32'(out_data_o), 32'h0);
        chk("mid_rst_vld",  32'(out_vld_o),  32'h0);
        chk("mid_rst_en",   32'(cfg_en_o),   32'h0);
        chk("mid_rst_sel",  32'(cfg_sel_o),  32'h0);
        rand_data();
        top_data_i = 16'h0010; data_vld_i = 1; data_ld_i = 1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            rand_data(); data_vld_i = 0;
            cyc();
            chk("post_rst_vld_early", 32'(out_vld_o), 32'h0);
        end
        rand_data(); data_vld_i = 0;
        cyc();
        chk("post_rst_data", 32'(out_data_o), 32'h0010);
        chk("post_rst_vld",  32'(out_vld_o),  32'h1);

        // Randomized mixed traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_data();
            if ($urandom_range(3) == 0) begin
                top_data_i[W-1:W-2] = 2'($urandom_range(1, 2));
            end
            rst_i      = ($urandom_range(49) == 0);
            cfg_ld_i   = ($urandom_range(3) == 0);
            cfg_en_i   = 1'($urandom);
            cfg_sel_i  = 1'($urandom);
            data_ld_i  = ($urandom_range(3) != 0);
            data_vld_i = 1'($urandom);
            clr_ovf_i  = ($urandom_range(15) == 0);
            cyc();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vertical_node_column.md
Name: vertical_node_column

Overview:
- Parametrised successor of the single vertical reduction node: a column of NUM_NODES cascaded add/bypass nodes in one block.
- Reduces a top-of-column partial sum with one per-node operand (mux path) per stage, fully registered per node.
- Adds a shift-loaded per-node config chain, optional saturation, sticky per-node overflow flags, and a valid pipeline that tracks bypass-dependent latency.
- Sits between the PE array mux outputs and the output accumulator of the sparse conv datapath.

Parameters:
- F_WIDTH, 8, fractional bits of the fixed-point data.
- I_WIDTH, 8, integer bits including sign; W = I_WIDTH + F_WIDTH.
- NUM_NODES, 4, number of cascaded nodes (>= 1).
- SATURATE, 1, 1 = clamp sums to the signed W-bit range; 0 = two's-complement wrap.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset; clears data, valid, config and overflow state.
- top_data_i  in  W  signed input to node 0.
- mux_data_i  in  NUM_NODES*W  per-node signed operands; node k uses bits [k*W +: W].
- data_vld_i  in  1  top_data_i is valid.
- data_ld_i  in  1  advance the data/valid pipeline; 0 = hold (stall).
- cfg_ld_i  in  1  shift the config chain by one node.
- cfg_en_i  in  1  add-enable bit entering node 0.
- cfg_sel_i  in  1  bypass-select bit entering node 0.
- clr_ovf_i  in  1  clear all sticky overflow flags.
- cfg_en_o  out  1  add-enable bit of the last node, for cascading columns.
- cfg_sel_o  out  1  bypass-select bit of the last node.
- out_data_o  out  W  signed column result (node NUM_NODES-1 output).
- out_vld_o  out  1  out_data_o is valid.
- ovf_o  out  NUM_NODES  sticky overflow flag per node.

Behaviour:
- Reset (rst_i=1 at an edge): every node register, valid bit, en, sel and ovf bit goes to 0. rst_i has priority over cfg_ld_i, data_ld_i and clr_ovf_i. After reset: out_data_o=0, out_vld_o=0, ovf_o=0, cfg_en_o=0, cfg_sel_o=0.
- Config chain: on cfg_ld_i=1, node 0 {en,sel} <= {cfg_en_i,cfg_sel_i}; node k {en,sel} <= node k-1 {en,sel}. The first bits shifted in end up in node NUM_NODES-1 after NUM_NODES loads. cfg_ld_i=0 holds config. Config and data loads are independent and may occur in the same cycle; the new config applies from the next cycle.
- Node input: in_0 = top_data_i; in_k = out_k-1 for k>=1. vin_0 = data_vld_i; vin_k = vout_k-1.
- Node sum: en_k=1 gives in_k + mux_k, computed at W+1 bits. With SATURATE=1 the result clamps to [-2^(W-1), 2^(W-1)-1]; with SATURATE=0 it wraps to W bits. en_k=0 gives sum = in_k, and mux_k is ignored.
- Overflow: a signed overflow at node k (en_k=1, data_ld_i=1) sets ovf_o[k], regardless of SATURATE. The bit stays set until rst_i or clr_ovf_i. If set and clear happen in the same cycle, set wins.
- Register: on data_ld_i=1, reg_k <= sum_k and vreg_k <= vin_k. On data_ld_i=0, both hold.
- Output mux: sel_k=1 gives out_k = in_k and vout_k = vin_k, combinationally, with the register unused. sel_k=0 gives out_k = reg_k and vout_k = vreg_k.
- Latency: data_ld cycles from input to output = number of nodes with sel=0. All sel=1 gives a zero-latency combinational path.
- out_data_o = out_(NUM_NODES-1); out_vld_o = vout_(NUM_NODES-1).
- Reset mid-stream drops all in-flight data and valids. No partial results may appear afterwards.

Test Plan (NUM_NODES=4, I_WIDTH=F_WIDTH=8, SATURATE=1):
- Reset: hold rst_i 2 cycles with random inputs -> out_data_o=0, out_vld_o=0, ovf_o=4'b0000, cfg_en_o=0, cfg_sel_o=0.
- Full add: shift 4x {en=1,sel=0}; drive top=0x0100, all mux=0x0080, data_vld_i=1, data_ld_i=1 each cycle -> out_vld_o rises on 4th load edge with out_data_o=0x0300.
- Bypass: config nodes 1,2 sel=1, nodes 0,3 sel=0 (en=1); top=0x0100, mux0=0x0040, mux3=0x0020 -> result 0x0160 valid after 2 loads; mux1/mux2 values have no effect.
- Saturation/overflow: config all en=1, sel=0; top=0x7F00, mux0=0x0200 -> node0=0x7FFF, ovf_o[0]=1 and stays 1 until clr_ovf_i pulse. Negative case: top=0x8100, mux0=0xFE00 -> 0x8000.
- Stall: deassert data_ld_i for 3 cycles mid-stream -> out_data_o/out_vld_o frozen; sequence resumes unchanged. Also check en=0 node: output equals input, with one-cycle register delay.
- Reset mid-operation: assert rst_i with data in flight -> next cycle all zero, config en/sel cleared; subsequent top=0x0010 with vld appears unmodified after 4 loads.
